// File: rtl/elevator_pkg.sv
// Shared types and door-timing defaults for the elevator door timer.
package elevator_pkg;

  typedef enum logic [1:0] {
    DT_IDLE = 2'd0,
    DT_RUN  = 2'd1,
    DT_HOLD = 2'd2,
    DT_DONE = 2'd3
  } door_timer_state_t;

  localparam int DT_TICK_DIV   = 1000;
  localparam int DT_OPEN_TICKS = 3;
  localparam int DT_MAX_EXTEND = 2;

  // Counter width that never collapses to zero bits for degenerate ranges.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/elevator_door_timer_sva.sv
// Invariant checks for the door timer, attached to an instance via bind.
module elevator_door_timer_sva #(
  parameter int OPEN_TICKS = 3,
  parameter int MAX_EXTEND = 2,
  parameter int RW         = 2,
  parameter int EW         = 2
) (
  input logic          clk_i,
  input logic          rst_i,
  input logic          done_i,
  input logic          busy_i,
  input logic          fault_i,
  input logic [RW-1:0] remaining_i,
  input logic [EW-1:0] extend_i
);

  a_done_not_busy: assert property (@(posedge clk_i) disable iff (!rst_i)
    done_i |-> !busy_i);

  a_fault_ext_max: assert property (@(posedge clk_i) disable iff (!rst_i)
    fault_i |-> (extend_i == EW'(MAX_EXTEND)));

  a_rem_bound: assert property (@(posedge clk_i) disable iff (!rst_i)
    remaining_i <= RW'(OPEN_TICKS));

endmodule

// File: rtl/elevator_tick_prescaler.sv
// Divides the clock into timer ticks: counts 0..TICK_DIV-1 while enabled.
module elevator_tick_prescaler
  import elevator_pkg::*;
#(
  parameter int TICK_DIV = DT_TICK_DIV
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int CW = clog2_min1(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)     cnt_d = '0;
    else if (tick_o) cnt_d = '0;
    else if (en_i)   cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/elevator_door_timer.sv
// Door-open timer with obstruction hold/re-arm and a bounded extension budget.
module elevator_door_timer
  import elevator_pkg::*;
#(
  parameter int TICK_DIV   = DT_TICK_DIV,
  parameter int OPEN_TICKS = DT_OPEN_TICKS,
  parameter int MAX_EXTEND = DT_MAX_EXTEND,
  localparam int RW        = $clog2(OPEN_TICKS + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          counter_init_i,
  input  logic          obstruct_i,
  output logic          counter_done_o,
  output logic          busy_o,
  output logic [RW-1:0] remaining_o,
  output logic          fault_o
);

  localparam int EW = clog2_min1(MAX_EXTEND + 1);
  localparam logic [RW-1:0] REM_INIT = RW'(OPEN_TICKS);
  localparam logic [EW-1:0] EXT_MAX  = EW'(MAX_EXTEND);

  if (TICK_DIV < 1 || OPEN_TICKS < 1) begin : g_bad_param
    $error("elevator_door_timer: TICK_DIV and OPEN_TICKS must be >= 1");
  end

  door_timer_state_t state_q, state_d;
  logic [RW-1:0] rem_q, rem_d;
  logic [EW-1:0] ext_q, ext_d;
  logic done_q, done_d, busy_q, busy_d, fault_q, fault_d;
  logic hold_req, pre_en, pre_clear, tick;

  // Obstruction wins over a same-cycle tick, so the prescaler is gated here.
  assign hold_req  = obstruct_i && (ext_q < EXT_MAX);
  assign pre_en    = !counter_init_i && (state_q == DT_RUN) && !hold_req;
  assign pre_clear = counter_init_i || ((state_q == DT_HOLD) && !obstruct_i);

  elevator_tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (pre_clear),
    .en_i    (pre_en),
    .tick_o  (tick)
  );

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    ext_d   = ext_q;
    done_d  = done_q;
    fault_d = fault_q;
    if (counter_init_i) begin
      state_d = DT_RUN;
      rem_d   = REM_INIT;
      ext_d   = '0;
      done_d  = 1'b0;
      fault_d = 1'b0;
    end else begin
      case (state_q)
        DT_RUN: begin
          if (hold_req) begin
            state_d = DT_HOLD;
          end else begin
            if (obstruct_i) fault_d = 1'b1;
            if (tick) begin
              if (rem_q > RW'(1)) begin
                rem_d = rem_q - RW'(1);
              end else begin
                rem_d   = '0;
                done_d  = 1'b1;
                state_d = DT_DONE;
              end
            end
          end
        end
        DT_HOLD: begin
          // ext_q < EXT_MAX held on entry, so this never exceeds the budget.
          if (!obstruct_i) begin
            ext_d   = ext_q + EW'(1);
            rem_d   = REM_INIT;
            state_d = DT_RUN;
          end
        end
        default: ;
      endcase
    end
    busy_d = (state_d == DT_RUN) || (state_d == DT_HOLD);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= DT_IDLE;
      rem_q   <= '0;
      ext_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      ext_q   <= ext_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      fault_q <= fault_d;
    end
  end

  assign counter_done_o = done_q;
  assign busy_o         = busy_q;
  assign remaining_o    = rem_q;
  assign fault_o        = fault_q;

endmodule

// File: tb/tb_elevator_door_timer.sv
// Directed bench for elevator_door_timer with TICK_DIV=4, OPEN_TICKS=3, MAX_EXTEND=2.
module tb_elevator_door_timer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       init = 1'b0;
  logic       obst = 1'b0;
  logic       done, busy, fault;
  logic [1:0] rem;
  int         n_chk = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  elevator_door_timer #(.TICK_DIV(4), .OPEN_TICKS(3), .MAX_EXTEND(2)) dut (
    .clk_i          (clk),
    .rst_i          (rst_n),
    .counter_init_i (init),
    .obstruct_i     (obst),
    .counter_done_o (done),
    .busy_o         (busy),
    .remaining_o    (rem),
    .fault_o        (fault)
  );

  bind elevator_door_timer elevator_door_timer_sva #(
    .OPEN_TICKS(OPEN_TICKS), .MAX_EXTEND(MAX_EXTEND), .RW(RW), .EW(EW)
  ) u_sva (
    .clk_i(clk_i), .rst_i(rst_i), .done_i(counter_done_o), .busy_i(busy_o),
    .fault_i(fault_o), .remaining_i(remaining_o), .extend_i(ext_q)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Each step leaves time 1ns past a rising edge: inputs change and outputs are sampled there.
  task automatic adv(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_init();
    init = 1'b1;
    adv(1);
    init = 1'b0;
  endtask

  initial begin
    // Reset values
    #2;
    chk("rst_done", 32'(done), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rem", 32'(rem), 0);
    chk("rst_fault", 32'(fault), 0);
    @(negedge clk);
    rst_n = 1'b1;
    adv(3);
    chk("idle_busy", 32'(busy), 0);

    // Plain count: done at edge 12
    pulse_init();
    chk("t1_busy0", 32'(busy), 1);
    chk("t1_rem0", 32'(rem), 3);
    adv(4);  chk("t1_rem4", 32'(rem), 2);
    adv(4);  chk("t1_rem8", 32'(rem), 1);
    adv(3);  chk("t1_done11", 32'(done), 0);
    adv(1);  chk("t1_done12", 32'(done), 1);
    chk("t1_busy12", 32'(busy), 0);
    chk("t1_rem12", 32'(rem), 0);
    obst = 1'b1;
    adv(20); chk("t1_done_hold", 32'(done), 1);
    chk("t1_busy_hold", 32'(busy), 0);
    obst = 1'b0;

    // Re-init at edge 6 of a running count: done 12 edges later
    pulse_init();
    adv(5);
    pulse_init();
    adv(6);  chk("t2_done_old12", 32'(done), 0);
    chk("t2_rem_old12", 32'(rem), 2);
    adv(5);  chk("t2_done11", 32'(done), 0);
    adv(1);  chk("t2_done12", 32'(done), 1);

    // Init held three edges: count restarts from the last init edge
    init = 1'b1;
    adv(3);
    init = 1'b0;
    adv(11); chk("t2b_done13", 32'(done), 0);
    adv(1);  chk("t2b_done14", 32'(done), 1);

    // Obstruction sampled edges 5..9
    pulse_init();
    adv(4);  chk("t3_rem4", 32'(rem), 2);
    obst = 1'b1;
    adv(1);  chk("t3_busy5", 32'(busy), 1);
    chk("t3_rem5", 32'(rem), 2);
    adv(4);  chk("t3_rem9", 32'(rem), 2);
    obst = 1'b0;
    adv(1);  chk("t3_rem10", 32'(rem), 3);
    chk("t3_fault10", 32'(fault), 0);
    adv(11); chk("t3_done21", 32'(done), 0);
    adv(1);  chk("t3_done22", 32'(done), 1);
    chk("t3_fault22", 32'(fault), 0);

    // Three obstructions: two re-arm, third faults and is ignored
    pulse_init();
    for (int k = 0; k < 2; k++) begin
      adv(1);
      obst = 1'b1;
      adv(2);
      obst = 1'b0;
      adv(1);
      chk($sformatf("t4_rearm%0d_rem", k), 32'(rem), 3);
      chk($sformatf("t4_rearm%0d_fault", k), 32'(fault), 0);
    end
    obst = 1'b1;
    adv(1);  chk("t4_fault_set", 32'(fault), 1);
    chk("t4_busy", 32'(busy), 1);
    adv(3);  chk("t4_rem_counts", 32'(rem), 2);
    obst = 1'b0;
    adv(7);  chk("t4_done11", 32'(done), 0);
    adv(1);  chk("t4_done12", 32'(done), 1);
    chk("t4_fault_sticky", 32'(fault), 1);
    pulse_init();
    chk("t4_fault_clr", 32'(fault), 0);
    chk("t4_done_clr", 32'(done), 0);

    // Async reset at edge 7 of the count just started
    adv(7);
    rst_n = 1'b0;
    #1;
    chk("t5_busy", 32'(busy), 0);
    chk("t5_rem", 32'(rem), 0);
    chk("t5_done", 32'(done), 0);
    chk("t5_fault", 32'(fault), 0);
    @(negedge clk);
    rst_n = 1'b1;
    adv(20); chk("t5_no_done", 32'(done), 0);
    chk("t5_no_busy", 32'(busy), 0);

    // Init and obstruct together: init wins, HOLD from the next edge
    init = 1'b1;
    obst = 1'b1;
    adv(1);
    init = 1'b0;
    chk("t6_busy0", 32'(busy), 1);
    chk("t6_rem0", 32'(rem), 3);
    adv(5);  chk("t6_rem_frozen5", 32'(rem), 3);
    obst = 1'b0;
    adv(1);  chk("t6_rem6", 32'(rem), 3);
    adv(11); chk("t6_done17", 32'(done), 0);
    adv(1);  chk("t6_done18", 32'(done), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
